// File: rtl/tt_serial_addsub_pkg.sv
// Shared types and pin map for the bit-serial add/subtract tile.
package tt_serial_addsub_pkg;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  localparam logic MODE_SUB = 1'b0;
  localparam logic MODE_ADD = 1'b1;

  localparam int unsigned UIO_LOAD_A = 7;
  localparam int unsigned UIO_START  = 6;
  localparam int unsigned UIO_MODE   = 3;
  localparam int unsigned UIO_BUSY   = 0;
  localparam int unsigned UIO_DONE   = 1;
  localparam int unsigned UIO_FLAG   = 2;

  localparam logic [7:0] UIO_OE_MASK = 8'h07;

endpackage

// File: rtl/serial_addsub_cell.sv
// One-bit full adder / full subtractor; cy is carry for add, borrow for sub.
module serial_addsub_cell
  import tt_serial_addsub_pkg::*;
(
  input  logic a_i,
  input  logic b_i,
  input  logic cy_i,
  input  logic mode_i,
  output logic s_o,
  output logic cy_o
);

  logic axb;

  always_comb begin
    axb = a_i ^ b_i;
    s_o = axb ^ cy_i;
    if (mode_i == MODE_ADD) begin
      cy_o = (a_i & b_i) | (cy_i & axb);
    end else begin
      cy_o = (~a_i & b_i) | (~axb & cy_i);
    end
  end

endmodule

// File: rtl/tt_um_serial_addsub.sv
// Bit-serial 8-bit adder/subtractor tile: load A, start with B, result after 8 clocks.
module tt_um_serial_addsub
  import tt_serial_addsub_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               cy_q, cy_d;
  logic               mode_q, mode_d;
  logic               start_q, start_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               flag_q, flag_d;

  logic start_pulse;
  logic load_a;
  logic s_bit;
  logic cy_next;
  logic unused_uio;

  assign unused_uio  = ^{uio_in[5:4], uio_in[2:0]};
  assign start_pulse = uio_in[UIO_START] & ~start_q;
  assign load_a      = uio_in[UIO_LOAD_A];

  serial_addsub_cell u_cell (
    .a_i   (a_q[0]),
    .b_i   (b_q[0]),
    .cy_i  (cy_q),
    .mode_i(mode_q),
    .s_o   (s_bit),
    .cy_o  (cy_next)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    cy_d    = cy_q;
    mode_d  = mode_q;
    start_d = uio_in[UIO_START];
    busy_d  = busy_q;
    done_d  = done_q;
    flag_d  = flag_q;

    unique case (state_q)
      StShift: begin
        // Operands drain LSB first; A is left at zero, so each op needs a fresh load.
        a_d   = {1'b0, a_q[WIDTH-1:1]};
        b_d   = {1'b0, b_q[WIDTH-1:1]};
        acc_d = {s_bit, acc_q[WIDTH-1:1]};
        cy_d  = cy_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          res_d   = {s_bit, acc_q[WIDTH-1:1]};
          flag_d  = cy_next;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = StDone;
        end
      end
      default: begin
        if (start_pulse) begin
          b_d     = ui_in;
          mode_d  = uio_in[UIO_MODE];
          cy_d    = 1'b0;
          cnt_d   = '0;
          done_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = StShift;
        end else if (load_a) begin
          a_d = ui_in;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      cy_q    <= 1'b0;
      mode_q  <= MODE_SUB;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      flag_q  <= 1'b0;
    end else if (ena) begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      cy_q    <= cy_d;
      mode_q  <= mode_d;
      start_q <= start_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      flag_q  <= flag_d;
    end
  end

  always_comb begin
    uo_out            = res_q;
    uio_out           = '0;
    uio_out[UIO_BUSY] = busy_q;
    uio_out[UIO_DONE] = done_q;
    uio_out[UIO_FLAG] = flag_q;
    uio_oe            = UIO_OE_MASK;
  end

endmodule

// File: tb/tb_tt_um_serial_addsub.sv
// Scoreboard bench for the bit-serial add/subtract tile.
module tb_tt_um_serial_addsub;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  typedef struct packed {
    logic [7:0] res;
    logic       flag;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] a_model;
  int         n_vec;
  int         n_err;

  tt_um_serial_addsub dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic add);
    exp_t        e;
    logic [8:0]  t;
    if (add) begin
      t      = {1'b0, a} + {1'b0, b};
      e.flag = t[8];
    end else begin
      t      = {1'b0, a} - {1'b0, b};
      e.flag = (a < b);
    end
    e.res = t[7:0];
    return e;
  endfunction

  task automatic do_load_a(input logic [7:0] v);
    @(posedge clk); #1;
    ui_in     = v;
    uio_in[7] = 1'b1;
    @(posedge clk); #1;
    uio_in[7] = 1'b0;
    a_model   = v;
  endtask

  // Drives a one-cycle start and queues the expected result.
  task automatic start_op(input logic [7:0] b, input logic add);
    ui_in     = b;
    uio_in[3] = add;
    uio_in[6] = 1'b1;
    @(posedge clk); #1;
    uio_in[6] = 1'b0;
    sb.push_back(model(a_model, b, add));
    a_model = 8'h00;
  endtask

  task automatic wait_done(output int busy_cnt, output bit timeout);
    busy_cnt = 0;
    timeout  = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (uio_out[1]) begin
        timeout = 1'b0;
        return;
      end
      if (uio_out[0]) busy_cnt++;
    end
  endtask

  task automatic test_reset();
    #3;
    n_vec++;
    if (uo_out !== 8'h00 || uio_out !== 8'h00 || uio_oe !== 8'h07) begin
      n_err++;
      $display("FAIL reset: uo_out=%h uio_out=%h uio_oe=%h, want 00 00 07",
               uo_out, uio_out, uio_oe);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic(input logic [7:0] a, input logic [7:0] b, input logic add,
                            input string name);
    int   bc;
    bit   to;
    exp_t e;
    do_load_a(a);
    start_op(b, add);
    wait_done(bc, to);
    e = sb.pop_front();
    n_vec++;
    if (to || uo_out !== e.res || uio_out[2] !== e.flag) begin
      n_err++;
      $display("FAIL %s result: timeout=%0d uo_out=%h flag=%b, want %h flag=%b",
               name, to, uo_out, uio_out[2], e.res, e.flag);
    end
    n_vec++;
    if (bc != 8 || uio_out[7:3] !== 5'b0) begin
      n_err++;
      $display("FAIL %s busy: busy cycles=%0d uio_out=%h, want 8 and upper bits 0",
               name, bc, uio_out);
    end
  endtask

  task automatic test_start_held();
    int   bc;
    bit   seen_done;
    exp_t e;
    do_load_a(8'h37);
    ui_in     = 8'h21;
    uio_in[3] = 1'b1;
    uio_in[6] = 1'b1;
    sb.push_back(model(a_model, 8'h21, 1'b1));
    a_model   = 8'h00;
    bc        = 0;
    seen_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (uio_out[0]) bc++;
      if (uio_out[1]) seen_done = 1'b1;
      if (i == 3) ui_in = 8'hFF;
    end
    uio_in[6] = 1'b0;
    e = sb.pop_front();
    n_vec++;
    if (bc != 8 || !seen_done) begin
      n_err++;
      $display("FAIL held_start busy: busy cycles=%0d done_seen=%0d, want 8 and 1",
               bc, seen_done);
    end
    n_vec++;
    if (uo_out !== e.res || uio_out[2] !== e.flag || uio_out[1] !== 1'b1) begin
      n_err++;
      $display("FAIL held_start result: uo_out=%h flag=%b done=%b, want %h flag=%b done=1",
               uo_out, uio_out[2], uio_out[1], e.res, e.flag);
    end
  endtask

  task automatic test_pulses_in_shift();
    int   bc;
    bit   to;
    exp_t e;
    do_load_a(8'h90);
    start_op(8'h11, 1'b0);
    fork
      begin
        @(posedge clk); #1;
        ui_in = 8'hAA; uio_in[7] = 1'b1; uio_in[6] = 1'b1; uio_in[3] = 1'b1;
        @(posedge clk); #1;
        uio_in[7] = 1'b0; uio_in[6] = 1'b0;
        @(posedge clk); #1;
        uio_in[6] = 1'b1;
        @(posedge clk); #1;
        uio_in[6] = 1'b0;
      end
    join_none
    wait_done(bc, to);
    e = sb.pop_front();
    n_vec++;
    if (to || bc != 8 || uo_out !== e.res || uio_out[2] !== e.flag) begin
      n_err++;
      $display("FAIL shift_pulses: timeout=%0d busy=%0d uo_out=%h flag=%b, want 8 %h %b",
               to, bc, uo_out, uio_out[2], e.res, e.flag);
    end
    // A was consumed and the in-shift load_a ignored, so this computes 0 + 5.
    start_op(8'h05, 1'b1);
    wait_done(bc, to);
    e = sb.pop_front();
    n_vec++;
    if (to || uo_out !== e.res || uio_out[2] !== e.flag) begin
      n_err++;
      $display("FAIL a_consumed: timeout=%0d uo_out=%h flag=%b, want %h flag=%b",
               to, uo_out, uio_out[2], e.res, e.flag);
    end
  endtask

  task automatic test_ena_gap();
    int   bc;
    bit   to;
    exp_t e;
    do_load_a(8'hB7);
    start_op(8'h4C, 1'b1);
    fork
      begin
        repeat (3) @(posedge clk);
        #1 ena = 1'b0;
        repeat (5) @(posedge clk);
        #1 ena = 1'b1;
      end
    join_none
    wait_done(bc, to);
    e = sb.pop_front();
    n_vec++;
    if (to || bc != 13) begin
      n_err++;
      $display("FAIL ena_gap busy: timeout=%0d busy cycles=%0d, want 13", to, bc);
    end
    n_vec++;
    if (uo_out !== e.res || uio_out[2] !== e.flag) begin
      n_err++;
      $display("FAIL ena_gap result: uo_out=%h flag=%b, want %h flag=%b",
               uo_out, uio_out[2], e.res, e.flag);
    end
  endtask

  task automatic test_load_and_start();
    int   bc;
    bit   to;
    exp_t e;
    do_load_a(8'h10);
    uio_in[7] = 1'b1;
    start_op(8'h03, 1'b1);
    uio_in[7] = 1'b0;
    wait_done(bc, to);
    e = sb.pop_front();
    n_vec++;
    if (to || uo_out !== e.res || uio_out[2] !== e.flag) begin
      n_err++;
      $display("FAIL load_and_start: timeout=%0d uo_out=%h flag=%b, want %h flag=%b",
               to, uo_out, uio_out[2], e.res, e.flag);
    end
  endtask

  task automatic test_async_reset();
    exp_t e;
    do_load_a(8'h42);
    start_op(8'h07, 1'b1);
    repeat (4) @(negedge clk);
    n_vec++;
    if (uio_out[0] !== 1'b1 || uo_out === 8'h00) begin
      n_err++;
      $display("FAIL pre_reset: busy=%b uo_out=%h, want busy 1 and old result", uio_out[0],
               uo_out);
    end
    e = sb.pop_front();
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if (uo_out !== 8'h00 || uio_out !== 8'h00) begin
      n_err++;
      $display("FAIL async_reset: uo_out=%h uio_out=%h, want 00 00", uo_out, uio_out);
    end
    @(negedge clk);
    rst_n   = 1'b1;
    a_model = 8'h00;
    test_basic(8'h9C, 8'h2B, 1'b0, "after_reset");
  endtask

  initial begin
    rst_n   = 1'b0;
    ena     = 1'b1;
    ui_in   = 8'h00;
    uio_in  = 8'h00;
    a_model = 8'h00;
    n_vec   = 0;
    n_err   = 0;
    test_reset();
    test_basic(8'h64, 8'h3A, 1'b0, "sub");
    test_basic(8'h05, 8'h0A, 1'b0, "sub_borrow");
    test_basic(8'hC8, 8'h64, 1'b1, "add_carry");
    test_basic(8'h01, 8'h02, 1'b1, "add_small");
    test_basic(8'h80, 8'h80, 1'b0, "sub_equal");
    test_basic(8'hFF, 8'h01, 1'b1, "add_wrap");
    test_start_held();
    test_pulses_in_shift();
    test_ena_gap();
    test_load_and_start();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
